// File: rtl/pc_count.sv
// Program counter for the instruction-fetch stage: step, absolute load or stall
// on each rising edge, with a one-cycle wrap pulse on step overflow.
module pc_count #(
  parameter int WIDTH    = 8,
  parameter int STEP     = 1,
  parameter int RESET_PC = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             model_sel,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] pc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_PC);

  logic [WIDTH-1:0] r_pc;
  logic             r_wrap;
  logic [WIDTH:0]   w_sum;

  // Extra MSB of the sum is the carry-out that drives the wrap pulse.
  assign w_sum = {1'b0, r_pc} + {1'b0, STEP_W};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc   <= RESET_W;
      r_wrap <= 1'b0;
    end else if (!en) begin
      r_wrap <= 1'b0;
    end else if (model_sel) begin
      r_pc   <= load_value;
      r_wrap <= 1'b0;
    end else begin
      r_pc   <= w_sum[WIDTH-1:0];
      r_wrap <= w_sum[WIDTH];
    end
  end

  assign pc   = r_pc;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_pc_count.sv
// Self-checking bench for pc_count: directed scenarios plus randomized traffic
// compared against an integer-arithmetic reference model.
module tb_pc_count;

  localparam int WIDTH = 8;
  localparam int STEP  = 1;
  localparam int MOD   = 1 << WIDTH;

  logic             clk;
  logic             reset;
  logic             en;
  logic             model_sel;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] pc;
  logic             wrap;

  int n_tests;
  int n_fail;
  int m_pc;
  int m_wrap;

  pc_count #(.WIDTH(WIDTH), .STEP(STEP), .RESET_PC(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .model_sel  (model_sel),
    .load_value (load_value),
    .pc         (pc),
    .wrap       (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".pc"}, int'(pc), m_pc);
    chk({tag, ".wrap"}, int'(wrap), m_wrap);
  endtask

  // Drive inputs, take one edge, update the reference and compare.
  task automatic cycle(input logic e, input logic s, input int lv, input string tag);
    int sum;
    en         = e;
    model_sel  = s;
    load_value = WIDTH'(lv);
    @(posedge clk);
    #1;
    if (!e) begin
      m_wrap = 0;
    end else if (s) begin
      m_pc   = lv % MOD;
      m_wrap = 0;
    end else begin
      sum    = m_pc + STEP;
      m_pc   = sum % MOD;
      m_wrap = (sum >= MOD) ? 1 : 0;
    end
    chk_state(tag);
  endtask

  // Asynchronous reset pulse placed between edges; pc must clear before any edge.
  task automatic reset_pulse(input string tag);
    #2;
    reset = 1'b0;
    #1;
    m_pc   = 0;
    m_wrap = 0;
    chk_state(tag);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    reset      = 1'b0;
    en         = 1'b1;
    model_sel  = 1'b1;
    load_value = 8'd99;
    m_pc       = 0;
    m_wrap     = 0;
    #1;
    chk_state("reset_at_start");
    @(posedge clk);
    #1;
    chk_state("reset_held_edge");
    reset = 1'b1;

    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 0, "step_from_reset");
    chk("step_reached_10", int'(pc), 10);

    cycle(1'b1, 1'b1, 8'h3A, "load_3a");
    reset_pulse("async_reset_from_3a");
    cycle(1'b0, 1'b0, 0, "stall_after_reset");

    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 0, "step_to_12");
    chk("at_12", int'(pc), 12);
    cycle(1'b1, 1'b1, 55, "load_55");
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 0, "resume_after_load");
    chk("resumed_58", int'(pc), 58);

    cycle(1'b1, 1'b1, 20, "load_20");
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 1'(i % 2 == 0), int'($urandom_range(0, 255)), "stall_hold_20");
    chk("stall_pc_20", int'(pc), 20);
    cycle(1'b1, 1'b0, 0, "step_after_stall");
    chk("after_stall_21", int'(pc), 21);

    cycle(1'b1, 1'b1, 255, "load_255_nowrap");
    chk("load_255_wrap0", int'(wrap), 0);
    cycle(1'b1, 1'b1, 254, "load_254");
    cycle(1'b1, 1'b0, 0, "step_255");
    cycle(1'b1, 1'b0, 0, "step_wrap_0");
    chk("wrap_pulse", int'(wrap), 1);
    cycle(1'b1, 1'b0, 0, "step_1_after_wrap");
    chk("wrap_cleared", int'(wrap), 0);

    // Reset asserted in the same cycle as a load of 99; the load must never land.
    en         = 1'b1;
    model_sel  = 1'b1;
    load_value = 8'd99;
    #3;
    reset  = 1'b0;
    m_pc   = 0;
    m_wrap = 0;
    #1;
    chk_state("reset_vs_load99_async");
    @(posedge clk);
    #1;
    chk_state("reset_vs_load99_edge");
    reset = 1'b1;
    cycle(1'b1, 1'b0, 0, "first_step_after_release");
    chk("first_step_is_1", int'(pc), 1);

    for (int i = 0; i < 400; i++) begin
      int lv;
      logic e;
      logic s;
      e  = ($urandom_range(0, 7) != 0);
      s  = ($urandom_range(0, 5) == 0);
      lv = ($urandom_range(0, 1) == 1) ? int'($urandom_range(245, 255))
                                       : int'($urandom_range(0, 255));
      cycle(e, s, lv, "random");
      if ($urandom_range(0, 49) == 0) reset_pulse("random_reset");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_count.md
# pc_count

Program-counter register for the CPU's instruction-fetch stage. It holds the current instruction address `pc` and does one of three things on each clock edge: steps it forward, loads an absolute target (jump/branch), or holds it (stall). The fetch logic uses `pc` directly as the instruction-memory address; the control unit drives `model_sel`, `load_value` and `en`.

## Interface
Parameters:
- `WIDTH`, default 8: address width of `pc` and `load_value`.
- `STEP`, default 1: increment applied in step mode; taken modulo 2^WIDTH.
- `RESET_PC`, default 0: value of `pc` while reset is asserted.

Ports:
- `clk`  input  1: single clock; all state changes on the rising edge.
- `reset`  input  1: asynchronous, active-low reset (0 = reset asserted).
- `en`  input  1: update enable; 0 freezes `pc` (stall).
- `model_sel`  input  1: mode select; 0 = step, 1 = load.
- `load_value`  input  WIDTH: absolute target written to `pc` in load mode.
- `pc`  output  WIDTH: current program counter, registered.
- `wrap`  output  1: registered one-cycle pulse, set on the edge where a step overflows past 2^WIDTH−1.

## Operation
- Reset (`reset`=0): `pc` = `RESET_PC` and `wrap` = 0 immediately, independent of `clk`. While reset is held, all other inputs are ignored.
- On each rising `clk` edge with `reset`=1, priority is:
  1. `en`=0: `pc` holds, `wrap` <= 0.
  2. `en`=1, `model_sel`=1: `pc` <= `load_value`, `wrap` <= 0.
  3. `en`=1, `model_sel`=0: `pc` <= (`pc` + `STEP`) mod 2^WIDTH, `wrap` <= carry-out of that addition.
- Load takes precedence over step in the same cycle. `en` gates both load and step.
- Arithmetic is unsigned, WIDTH bits, and silently wraps; no saturation.
- `load_value` is sampled only on the edge where the load is taken. At all other times it is don't-care.
- No X propagation: `pc` must be defined on every cycle after the first reset.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on `pc` just after edge N.
- There is no combinational path from any input to `pc` or `wrap`.
- Reset assertion is asynchronous. Deassertion takes effect at the first rising edge where `reset`=1 is sampled, so the first step from `RESET_PC` happens on that edge if `en`=1.
- Reset asserted mid-operation overrides any load or step in progress. `pc` goes to `RESET_PC` without waiting for a clock.
- `model_sel` may change every cycle. A one-cycle `model_sel`=1 pulse performs exactly one load, and stepping resumes from the loaded value on the next edge.
- Wrap boundary, WIDTH=8, STEP=1: `pc`=255 steps to 0 with `wrap`=1 for exactly one cycle. A load of 255 does not set `wrap`.

## Test plan
- Reset: drive `reset`=0 between clock edges with `pc`=0x3A. `pc` must read 0 before the next edge and hold 0 while reset stays low.
- Step: release reset with `en`=1 and `model_sel`=0, then run 10 edges. `pc` must read 1, 2, …, 10, with `wrap`=0 throughout.
- Load then resume: from `pc`=12, give a one-cycle `model_sel`=1 with `load_value`=55, then `model_sel`=0. `pc` must read 55, 56, 57, … on successive edges.
- Stall: set `en`=0 for 3 edges at `pc`=20 while toggling `model_sel` and `load_value`. `pc` must stay 20. After `en` returns to 1 in step mode, `pc` = 21.
- Wrap: load 254, then step. `pc` must read 255, 0, 1, with `wrap`=1 only in the cycle `pc`=0.
- Reset mid-stream: assert `reset` in the same cycle as a load of 99. `pc` must go to 0, never 99. After release with `en`=1, the first edge must give `pc`=1.
